uart_tx_arbiter: RTL and testbench



---
 rtl/uart_ctrl_pkg.sv | 23 ++
 rtl/uart_sync2.sv | 33 +++
 rtl/uart_tx_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_ctrl_pkg
// Purpose  : Shared definitions for the UART transmit arbiter: FSM state
//            encoding and synchronizer depth.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package uart_ctrl_pkg;

  // Depth of the clock-domain-crossing synchronizers on tx_busy / tx_done.
  localparam int SYNC_STAGES = 2;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    GRANT     = 3'd1,
    LAUNCH    = 3'd2,
    WAIT_DONE = 3'd3,
    DRAIN     = 3'd4
  } state_e;

endpackage : uart_ctrl_pkg
`default_nettype wire

// File: rtl/uart_sync2.sv
`default_nettype none
// ============================================================================
// Module   : uart_sync2
// Purpose  : Two-flop synchronizer for a single-bit level signal coming from
//            the transmitter clock domain. Flops reset to 0.
// Ports    : clk - destination clock
//            rst - asynchronous active-high reset
//            i_d - asynchronous input level
//            o_q - synchronized output level
// Revision : 1.0 - initial release
// ============================================================================
module uart_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);
  import uart_ctrl_pkg::*;

  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[SYNC_STAGES-1];

endmodule : uart_sync2
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Round-robin arbiter that hands one byte at a time from NUM_REQ
//            requesters to a UART transmitter living in another clock domain.
//            Optional watchdog enabled by defining UART_TX_ARB_TIMEOUT_EN.
// Ports    : clk, rst            - clock, asynchronous active-high reset
//            req, req_data       - per-requester request level and byte
//            ack                 - one-cycle capture pulse per requester
//            owner               - index of current/last granted requester
//            busy                - high from capture until release
//            tx_en, tx_start     - transmitter enable / start
//            tx_data             - byte to the transmitter
//            tx_busy, tx_done    - transmitter status (tx clock domain)
//            timeout             - one-cycle watchdog abort pulse
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*8-1:0]       req_data,
  output logic [NUM_REQ-1:0]         ack,
  output logic [$clog2(NUM_REQ)-1:0] owner,
  output logic                       busy,
  output logic                       tx_en,
  output logic                       tx_start,
  output logic [7:0]                 tx_data,
  input  logic                       tx_busy,
  input  logic                       tx_done,
  output logic                       timeout
);
  import uart_ctrl_pkg::*;

  localparam int c_idx_w = $clog2(NUM_REQ);

  state_e               r_state;
  state_e               w_next;
  logic [c_idx_w-1:0]   r_rr_ptr;
  logic [c_idx_w-1:0]   r_owner;
  logic [7:0]           r_tx_data;
  logic [c_idx_w-1:0]   w_win;
  logic                 w_any;
  logic                 w_sbusy;
  logic                 w_sdone;
  logic                 r_sdone_q;
  logic                 w_sdone_rise;
  logic                 w_tmo;

  // --------------------------------------------------------------------------
  // Status synchronizers
  // --------------------------------------------------------------------------
  uart_sync2 u_sync_busy (
    .clk (clk),
    .rst (rst),
    .i_d (tx_busy),
    .o_q (w_sbusy)
  );

  uart_sync2 u_sync_done (
    .clk (clk),
    .rst (rst),
    .i_d (tx_done),
    .o_q (w_sdone)
  );

  assign w_sdone_rise = w_sdone & ~r_sdone_q;

  // --------------------------------------------------------------------------
  // Round-robin winner: first requester at or above rr_ptr, wrapping.
  // Scanning offsets from high to low lets the smallest offset win last.
  // --------------------------------------------------------------------------
  always_comb begin
    w_win = r_rr_ptr;
    w_any = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[(int'(r_rr_ptr) + k) % NUM_REQ]) begin
        w_win = c_idx_w'((int'(r_rr_ptr) + k) % NUM_REQ);
        w_any = 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Watchdog
  // --------------------------------------------------------------------------
`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int c_cnt_w = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [c_cnt_w-1:0] r_tmo_cnt;
  logic               r_timeout;

  assign w_tmo = ((r_state == LAUNCH) || (r_state == WAIT_DONE)) &&
                 (r_tmo_cnt == c_cnt_w'(TIMEOUT_CYCLES - 1));

  // Counter is zeroed while in GRANT so it starts at 0 on LAUNCH entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tmo_cnt <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_tmo;
      if (r_state == GRANT) begin
        r_tmo_cnt <= '0;
      end else if ((r_state == LAUNCH) || (r_state == WAIT_DONE)) begin
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end
    end
  end

  assign timeout = r_timeout;
`else
  logic w_unused_tmo;

  assign w_tmo        = 1'b0;
  assign timeout      = 1'b0;
  assign w_unused_tmo = ^TIMEOUT_CYCLES;
`endif

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next state and outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_next   = r_state;
    tx_en    = 1'b0;
    tx_start = 1'b0;
    busy     = 1'b1;
    ack      = '0;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (w_any) begin
          w_next = GRANT;
        end
      end
      GRANT: begin
        ack    = NUM_REQ'(1) << r_owner;
        w_next = LAUNCH;
      end
      LAUNCH: begin
        tx_en    = 1'b1;
        tx_start = 1'b1;
        if (w_tmo) begin
          w_next = DRAIN;
        end else if (w_sbusy) begin
          w_next = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        tx_en = 1'b1;
        if (w_tmo || w_sdone_rise) begin
          w_next = DRAIN;
        end
      end
      DRAIN: begin
        // Wait for both status lines to settle low so a lingering done
        // cannot be mistaken for completion of the next byte.
        if (!w_sbusy && !w_sdone) begin
          w_next = IDLE;
        end
      end
      default: begin
        w_next = IDLE;
        busy   = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: owner and byte are captured on the IDLE->GRANT edge so both
  // are already valid while ack is pulsed in GRANT; the pointer advances
  // as GRANT is left.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner   <= '0;
      r_tx_data <= '0;
      r_rr_ptr  <= '0;
      r_sdone_q <= 1'b0;
    end else begin
      r_sdone_q <= w_sdone;
      if ((r_state == IDLE) && w_any) begin
        r_owner   <= w_win;
        r_tx_data <= req_data[int'(w_win) * 8 +: 8];
      end
      if (r_state == GRANT) begin
        r_rr_ptr <= c_idx_w'((int'(r_owner) + 1) % NUM_REQ);
      end
    end
  end

  assign owner   = r_owner;
  assign tx_data = r_tx_data;

endmodule : uart_tx_arbiter
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Purpose  : Self-checking bench for uart_tx_arbiter: directed vector table,
//            hand-written corner sequences and a randomized run against a
//            round-robin reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int TMO = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N-1:0]     req = '0;
  logic [N*8-1:0]   req_data = '0;
  logic [N-1:0]     ack;
  logic [1:0]       owner;
  logic             busy, tx_en, tx_start, timeout;
  logic [7:0]       tx_data;
  logic             tx_busy = 1'b0;
  logic             tx_done = 1'b0;

  int checks = 0;
  int errors = 0;

  uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TMO)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_data (req_data),
    .ack      (ack),
    .owner    (owner),
    .busy     (busy),
    .tx_en    (tx_en),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  // Transmitter model: on tx_start raise busy for a few cycles, then hold
  // done for tm_hold cycles (random lengths when tm_rand is set).
  bit tm_en   = 1'b1;
  bit tm_rand = 1'b0;
  int tm_hold = 2;
  int tm_phase = 0;
  int tm_cnt = 0;

  always @(negedge clk) begin
    if (rst) begin
      tm_phase = 0;
      tx_busy  = 1'b0;
      tx_done  = 1'b0;
    end else begin
      case (tm_phase)
        0: if (tm_en && tx_start) begin
             tx_busy  = 1'b1;
             tm_cnt   = tm_rand ? int'($urandom_range(1, 4)) : 3;
             tm_phase = 1;
           end
        1: begin
             tm_cnt--;
             if (tm_cnt <= 0) begin
               tx_busy  = 1'b0;
               tx_done  = 1'b1;
               tm_cnt   = tm_rand ? int'($urandom_range(1, 4)) : tm_hold;
               tm_phase = 2;
             end
           end
        default: begin
             tm_cnt--;
             if (tm_cnt <= 0) begin
               tx_done  = 1'b0;
               tm_phase = 0;
             end
           end
      endcase
    end
  end

  // Rising clock edges seen with tx_done low since it last was high.
  int quiet = 0;
  always @(posedge clk) begin
    if (tx_done) quiet = 0;
    else         quiet++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_ack(input string nm);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clk);
      if (|ack) ok = 1'b1;
    end
    chk(nm, 32'(ok), 1);
  endtask

  task automatic wait_idle(input string nm, output int hi);
    bit ok;
    ok = 1'b0;
    hi = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (tx_start) hi++;
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk(nm, 32'(ok), 1);
  endtask

  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  typedef struct {
    logic [N-1:0] r;
    logic [7:0]   d;
    int           eo;
    logic [7:0]   ed;
  } vec_t;

  vec_t tbl[8];
  int   rr_exp[6];

  initial begin
    int  n, hi, acks, starts, quiet_at, cnt, mptr, exp_o;
    bit  ok, prev_ts, pend;
    logic [7:0] pend_byte, exp_d;

    // Sequence from reset (rr_ptr=0); slot i carries d + 0x11*i.
    tbl[0] = '{4'b0100, 8'h83, 2, 8'hA5};
    tbl[1] = '{4'b0001, 8'h10, 0, 8'h10};
    tbl[2] = '{4'b1111, 8'h20, 1, 8'h31};
    tbl[3] = '{4'b1001, 8'h40, 3, 8'h73};
    tbl[4] = '{4'b1010, 8'h50, 1, 8'h61};
    tbl[5] = '{4'b0011, 8'h60, 0, 8'h60};
    tbl[6] = '{4'b0001, 8'h70, 0, 8'h70};
    tbl[7] = '{4'b1000, 8'h80, 3, 8'hB3};
    rr_exp = '{0, 1, 3, 0, 1, 3};

    // Reset state
    @(negedge clk);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_owner", 32'(owner), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_tx_en", 32'(tx_en), 0);
    chk("rst_tx_start", 32'(tx_start), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_timeout", 32'(timeout), 0);
    do_reset();

    // Directed table
    for (int t = 0; t < 8; t++) begin
      req = tbl[t].r;
      for (int i = 0; i < N; i++) req_data[i*8 +: 8] = tbl[t].d + 8'(i * 17);
      n = 0;
      ok = 1'b0;
      while (!ok && n < 50) begin
        @(negedge clk);
        n++;
        if (|ack) ok = 1'b1;
      end
      chk("tbl_ack_seen", 32'(ok), 1);
      chk("tbl_ack_latency", n, 1);
      chk("tbl_owner", 32'(owner), tbl[t].eo);
      chk("tbl_ack_vec", 32'(ack), 32'(1) << tbl[t].eo);
      chk("tbl_tx_data", 32'(tx_data), 32'(tbl[t].ed));
      chk("tbl_busy_grant", 32'(busy), 1);
      req = '0;
      @(negedge clk);
      chk("tbl_tx_start_lat2", 32'(tx_start), 1);
      chk("tbl_tx_en", 32'(tx_en), 1);
      wait_idle("tbl_idle", hi);
      chk("tbl_start_until_sbusy", hi, 2);
      chk("tbl_tx_data_hold", 32'(tx_data), 32'(tbl[t].ed));
    end

    // Round-robin with permanent requests
    do_reset();
    req = 4'b1011;
    for (int i = 0; i < N; i++) req_data[i*8 +: 8] = 8'hC0 + 8'(i);
    for (int k = 0; k < 6; k++) begin
      wait_ack("rr_ack_seen");
      chk("rr_owner", 32'(owner), rr_exp[k]);
      chk("rr_tx_data", 32'(tx_data), 32'hC0 + rr_exp[k]);
    end
    req = '0;
    wait_idle("rr_idle", hi);

    // Stale done held for 40 cycles with a new request pending
    tm_hold = 40;
    req = 4'b0010;
    req_data[15:8]  = 8'h5A;
    req_data[23:16] = 8'hC3;
    acks = 0;
    starts = 0;
    quiet_at = -1;
    prev_ts = 1'b0;
    for (int c = 0; c < 400 && starts < 2; c++) begin
      @(negedge clk);
      if (|ack) acks++;
      if (ack[1]) req = 4'b0100;
      if (ack[2]) req = '0;
      if (tx_start && !prev_ts) begin
        starts++;
        if (starts == 2) quiet_at = quiet;
      end
      prev_ts = tx_start;
    end
    tm_hold = 2;
    chk("stale_two_starts", starts, 2);
    chk("stale_quiet_edges", quiet_at, 5);
    chk("stale_second_data", 32'(tx_data), 32'hC3);
    wait_idle("stale_idle", hi);
    chk("stale_acks", acks, 2);

    // Reset during WAIT_DONE
    do_reset();
    req = 4'b0010;
    req_data[15:8] = 8'h3C;
    wait_ack("mid_ack_seen");
    req = '0;
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (tx_en && !tx_start) begin
        ok = 1'b1;
        break;
      end
    end
    chk("mid_wait_done_seen", 32'(ok), 1);
    rst = 1'b1;
    #1;
    chk("mid_tx_start", 32'(tx_start), 0);
    chk("mid_tx_en", 32'(tx_en), 0);
    chk("mid_busy", 32'(busy), 0);
    chk("mid_tx_data", 32'(tx_data), 0);
    chk("mid_owner", 32'(owner), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    acks = 0;
    repeat (6) begin
      @(negedge clk);
      if (|ack) acks++;
    end
    chk("mid_no_reack", acks, 0);
    chk("mid_idle", 32'(busy), 0);
    req = 4'b0110;
    wait_ack("mid_post_ack");
    chk("mid_ptr_cleared", 32'(owner), 1);
    req = '0;
    wait_idle("mid_post_idle", hi);

    // Watchdog with transmitter stuck
    tm_en = 1'b0;
    req = 4'b0001;
    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (|ack) req = '0;
      if (tx_start) begin
        ok = 1'b1;
        break;
      end
    end
    chk("tmo_launch_seen", 32'(ok), 1);
`ifdef UART_TX_ARB_TIMEOUT_EN
    n = 0;
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      n++;
      if (timeout) begin
        ok = 1'b1;
        break;
      end
    end
    chk("tmo_seen", 32'(ok), 1);
    chk("tmo_cycles", n, TMO);
    chk("tmo_tx_start_drop", 32'(tx_start), 0);
    chk("tmo_tx_en_drop", 32'(tx_en), 0);
    @(negedge clk);
    chk("tmo_one_cycle", 32'(timeout), 0);
    wait_idle("tmo_idle", hi);
    tm_en = 1'b1;
`else
    cnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (timeout) cnt++;
    end
    chk("notmo_timeout_low", cnt, 0);
    chk("notmo_still_launch", 32'(tx_start), 1);
    chk("notmo_busy", 32'(busy), 1);
    do_reset();
    tm_en = 1'b1;
`endif

    // Randomized run against round-robin model
    do_reset();
    tm_rand = 1'b1;
    mptr = 0;
    pend = 1'b0;
    pend_byte = '0;
    prev_ts = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (|ack) begin
        exp_o = rr_pick(req, mptr);
        exp_d = (exp_o >= 0) ? req_data[exp_o*8 +: 8] : 8'h00;
        chk("rnd_owner", 32'(owner), exp_o);
        chk("rnd_ack_vec", 32'(ack), (exp_o >= 0) ? (32'(1) << exp_o) : 0);
        chk("rnd_tx_data", 32'(tx_data), 32'(exp_d));
        chk("rnd_prev_launched", 32'(pend), 0);
        pend = 1'b1;
        pend_byte = exp_d;
        if (exp_o >= 0) mptr = (exp_o + 1) % N;
      end
      if (tx_start && !prev_ts) begin
        chk("rnd_start_pending", 32'(pend), 1);
        chk("rnd_start_data", 32'(tx_data), 32'(pend_byte));
        pend = 1'b0;
      end
      prev_ts = tx_start;
      for (int i = 0; i < N; i++) begin
        if (ack[i]) begin
          if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
          else req_data[i*8 +: 8] = 8'($urandom);
        end else if (!req[i] && $urandom_range(0, 5) == 0) begin
          req[i] = 1'b1;
          req_data[i*8 +: 8] = 8'($urandom);
        end
      end
    end
    req = '0;
    wait_idle("rnd_idle", hi);
    chk("rnd_final_launch", 32'(pend), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_uart_tx_arbiter
`default_nettype wire
